// File: rtl/riscboy_ppu_pixel_unpack_pkg.sv
// Shared PPU pixel constants: pixel-mode encodings and log2 bits-per-pixel.
// Imported by the pixel unpack stage and its sub-blocks.
package riscboy_ppu_pixel_unpack_pkg;

  typedef enum logic [1:0] {
    PIXMODE_ARGB1555 = 2'd0,
    PIXMODE_PAL8     = 2'd1,
    PIXMODE_PAL4     = 2'd2,
    PIXMODE_PAL1     = 2'd3
  } pixmode_t;

  // log2 of bits per pixel; 16bpp ARGB1555 gives 4.
  function automatic logic [2:0] pixmode_log_bpp(input pixmode_t mode);
    case (mode)
      PIXMODE_ARGB1555: return 3'd4;
      PIXMODE_PAL8:     return 3'd3;
      PIXMODE_PAL4:     return 3'd2;
      default:          return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/riscboy_ppu_pixel_unpack_if.sv
// Bus data-phase, pixel metadata and pixel output streams of the unpack stage.
// master = upstream/downstream environment, slave = the unpack stage.
interface riscboy_ppu_pixel_unpack_if #(
  parameter int W_DATA = 16
) ();

  logic              bus_data_vld;
  logic [W_DATA-1:0] bus_data;
  logic [3:0]        pinfo_u;
  logic              pinfo_discard;
  logic              pinfo_vld;
  logic              pinfo_rdy;
  logic              out_vld;
  logic              out_rdy;
  logic [W_DATA-1:0] out_data;
  logic              out_paletted;
  logic              out_discard;

  modport master (
    output bus_data_vld, bus_data, pinfo_u, pinfo_discard, pinfo_vld, out_rdy,
    input  pinfo_rdy, out_vld, out_data, out_paletted, out_discard
  );

  modport slave (
    input  bus_data_vld, bus_data, pinfo_u, pinfo_discard, pinfo_vld, out_rdy,
    output pinfo_rdy, out_vld, out_data, out_paletted, out_discard
  );

endinterface

// File: rtl/riscboy_ppu_pixel_unpack_sync_fifo.sv
// Synchronous FIFO with registered pointers; writes to a full FIFO are dropped.
// Read data is the current head (show-ahead), no write-to-read bypass.
module riscboy_ppu_pixel_unpack_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok;
  logic             rd_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wr_ok ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = rd_ok ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/riscboy_ppu_pixel_unpack.sv
// PPU pixel unpack: pairs returned bus halfwords with pixel metadata, extracts
// one pixel per the span's pixel mode and presents it on a registered stream.
module riscboy_ppu_pixel_unpack
  import riscboy_ppu_pixel_unpack_pkg::*;
#(
  parameter int W_DATA          = 16,
  parameter int DATA_FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        span_start,
  input  logic [1:0]                  span_pixmode,
  output logic                        span_idle,
  riscboy_ppu_pixel_unpack_if.slave   px,
  output logic                        err_overflow
);

  pixmode_t          pixmode_q, pixmode_d;
  logic              out_vld_q, out_vld_d;
  logic [W_DATA-1:0] out_data_q, out_data_d;
  logic              out_paletted_q, out_paletted_d;
  logic              out_discard_q, out_discard_d;
  logic              err_overflow_q, err_overflow_d;

  logic [W_DATA-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;
  logic              ld;
  logic              issue;

  // Little-endian within the halfword: pixel 0 sits in the LSBs.
  function automatic logic [15:0] extract_pixel(input logic [15:0] hw,
                                                input pixmode_t   mode,
                                                input logic [3:0] u);
    logic [3:0]  shamt;
    logic [15:0] shifted;
    shamt   = 4'(u << pixmode_log_bpp(mode));
    shifted = hw >> shamt;
    case (mode)
      PIXMODE_ARGB1555: return hw;
      PIXMODE_PAL8:     return {8'h00, shifted[7:0]};
      PIXMODE_PAL4:     return {12'h000, shifted[3:0]};
      default:          return {15'h0000, shifted[0]};
    endcase
  endfunction

  riscboy_ppu_pixel_unpack_sync_fifo #(
    .WIDTH (W_DATA),
    .DEPTH (DATA_FIFO_DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (px.bus_data_vld),
    .wr_data_i (px.bus_data),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign ld        = !out_vld_q || px.out_rdy;
  assign issue     = px.pinfo_vld && ld && (px.pinfo_discard || !fifo_empty);
  assign fifo_pop  = issue && !px.pinfo_discard;
  assign span_idle = !px.pinfo_vld && fifo_empty && !out_vld_q;

  assign px.pinfo_rdy    = issue;
  assign px.out_vld      = out_vld_q;
  assign px.out_data     = out_data_q;
  assign px.out_paletted = out_paletted_q;
  assign px.out_discard  = out_discard_q;
  assign err_overflow    = err_overflow_q;

  always_comb begin
    pixmode_d      = pixmode_q;
    out_vld_d      = out_vld_q;
    out_data_d     = out_data_q;
    out_paletted_d = out_paletted_q;
    out_discard_d  = out_discard_q;
    err_overflow_d = err_overflow_q || (px.bus_data_vld && fifo_full);
    if (span_start) pixmode_d = pixmode_t'(span_pixmode);
    if (issue) begin
      out_vld_d      = 1'b1;
      out_discard_d  = px.pinfo_discard;
      out_paletted_d = (pixmode_q != PIXMODE_ARGB1555);
      out_data_d     = px.pinfo_discard ? '0
                     : W_DATA'(extract_pixel(16'(fifo_head), pixmode_q, px.pinfo_u));
    end else if (px.out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixmode_q      <= PIXMODE_ARGB1555;
      out_vld_q      <= 1'b0;
      out_data_q     <= '0;
      out_paletted_q <= 1'b0;
      out_discard_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      pixmode_q      <= pixmode_d;
      out_vld_q      <= out_vld_d;
      out_data_q     <= out_data_d;
      out_paletted_q <= out_paletted_d;
      out_discard_q  <= out_discard_d;
      err_overflow_q <= err_overflow_d;
    end
  end

endmodule

// File: tb/tb_riscboy_ppu_pixel_unpack.sv
// Directed self-checking bench for riscboy_ppu_pixel_unpack.
module tb_riscboy_ppu_pixel_unpack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       span_start;
  logic [1:0] span_pixmode;
  logic       span_idle;
  logic       err_overflow;
  int         n_checks = 0;
  int         n_fail   = 0;

  riscboy_ppu_pixel_unpack_if #(.W_DATA(16)) px ();

  riscboy_ppu_pixel_unpack #(.W_DATA(16), .DATA_FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .span_start   (span_start),
    .span_pixmode (span_pixmode),
    .span_idle    (span_idle),
    .px           (px),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) assert (!(span_start && !span_idle)) else $error("span_start while span busy");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #3;
    n_checks++;
    if ({px.out_vld, px.out_data, px.out_paletted, px.out_discard, err_overflow} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0",
               {px.out_vld, px.out_data, px.out_paletted, px.out_discard, err_overflow});
    end
    n_checks++;
    if (span_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", span_idle); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_pal4;
    logic [15:0] exp [4] = '{16'h0003, 16'h000C, 16'h0005, 16'h000A};
    span_start = 1'b1; span_pixmode = 2'd2;
    px.bus_data_vld = 1'b1; px.bus_data = 16'hA5C3;
    tick();
    span_start = 1'b0;
    for (int i = 1; i < 4; i++) tick();
    px.bus_data_vld = 1'b0;
    n_checks++;
    if (span_idle !== 1'b0) begin n_fail++; $display("FAIL pal4_busy got=%b exp=0", span_idle); end
    for (int u = 0; u < 4; u++) begin
      px.pinfo_vld = 1'b1; px.pinfo_discard = 1'b0; px.pinfo_u = 4'(u);
      #1;
      n_checks++;
      if (px.pinfo_rdy !== 1'b1) begin n_fail++; $display("FAIL pal4_rdy%0d got=%b exp=1", u, px.pinfo_rdy); end
      tick();
      n_checks++;
      if ({px.out_vld, px.out_paletted, px.out_discard, px.out_data} !== {3'b110, exp[u]}) begin
        n_fail++;
        $display("FAIL pal4_pix%0d got vld/pal/dis/data=%b%b%b/%h exp=110/%h", u,
                 px.out_vld, px.out_paletted, px.out_discard, px.out_data, exp[u]);
      end
    end
    px.pinfo_vld = 1'b0;
    tick();
    n_checks++;
    if ({px.out_vld, span_idle} !== 2'b01) begin
      n_fail++; $display("FAIL pal4_end got vld/idle=%b%b exp=01", px.out_vld, span_idle);
    end
  endtask

  task automatic test_argb;
    span_start = 1'b1; span_pixmode = 2'd0;
    px.bus_data_vld = 1'b1; px.bus_data = 16'h8123;
    tick();
    span_start = 1'b0; px.bus_data_vld = 1'b0;
    px.pinfo_vld = 1'b1; px.pinfo_discard = 1'b0; px.pinfo_u = 4'd7;
    tick();
    n_checks++;
    if ({px.out_vld, px.out_paletted, px.out_discard, px.out_data} !== {3'b100, 16'h8123}) begin
      n_fail++;
      $display("FAIL argb_pix got vld/pal/dis/data=%b%b%b/%h exp=100/8123",
               px.out_vld, px.out_paletted, px.out_discard, px.out_data);
    end
    px.pinfo_vld = 1'b0;
    tick();
    n_checks++;
    if (span_idle !== 1'b1) begin n_fail++; $display("FAIL argb_idle got=%b exp=1", span_idle); end
  endtask

  task automatic test_pal1;
    logic [3:0]  us  [3] = '{4'd0, 4'd15, 4'd1};
    logic [15:0] exp [3] = '{16'h0001, 16'h0001, 16'h0000};
    span_start = 1'b1; span_pixmode = 2'd3;
    px.bus_data_vld = 1'b1; px.bus_data = 16'h8001;
    tick();
    span_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      px.bus_data_vld = (i < 2);
      px.pinfo_vld = 1'b1; px.pinfo_discard = 1'b0; px.pinfo_u = us[i];
      tick();
      n_checks++;
      if ({px.out_vld, px.out_paletted, px.out_data} !== {2'b11, exp[i]}) begin
        n_fail++;
        $display("FAIL pal1_pix%0d got vld/pal/data=%b%b/%h exp=11/%h", i,
                 px.out_vld, px.out_paletted, px.out_data, exp[i]);
      end
    end
    px.bus_data_vld = 1'b0; px.pinfo_vld = 1'b0;
    tick();
    n_checks++;
    if (span_idle !== 1'b1) begin n_fail++; $display("FAIL pal1_idle got=%b exp=1", span_idle); end
  endtask

  task automatic test_discard;
    logic        dis [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] exp [3] = '{16'h0000, 16'h003C, 16'h0000};
    span_start = 1'b1; span_pixmode = 2'd1;
    tick();
    span_start = 1'b0;
    px.bus_data_vld = 1'b1; px.bus_data = 16'h3C7E;
    for (int i = 0; i < 3; i++) begin
      px.pinfo_vld = 1'b1; px.pinfo_discard = dis[i]; px.pinfo_u = 4'd1;
      #1;
      n_checks++;
      if (px.pinfo_rdy !== 1'b1) begin n_fail++; $display("FAIL disc_rdy%0d got=%b exp=1", i, px.pinfo_rdy); end
      tick();
      px.bus_data_vld = 1'b0;
      n_checks++;
      if ({px.out_vld, px.out_paletted, px.out_discard, px.out_data} !== {2'b11, dis[i], exp[i]}) begin
        n_fail++;
        $display("FAIL disc_pix%0d got vld/pal/dis/data=%b%b%b/%h exp=11%b/%h", i,
                 px.out_vld, px.out_paletted, px.out_discard, px.out_data, dis[i], exp[i]);
      end
    end
    px.pinfo_vld = 1'b0; px.pinfo_discard = 1'b0;
    tick();
    n_checks++;
    if ({px.out_vld, span_idle} !== 2'b01) begin
      n_fail++; $display("FAIL disc_end got vld/idle=%b%b exp=01", px.out_vld, span_idle);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] hw  [4] = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
    logic [15:0] exp [4] = '{16'h0022, 16'h0033, 16'h0066, 16'h0077};
    span_start = 1'b1; span_pixmode = 2'd1; px.out_rdy = 1'b0;
    tick();
    span_start = 1'b0;
    px.pinfo_vld = 1'b1; px.pinfo_discard = 1'b1;
    tick();
    px.pinfo_discard = 1'b0; px.pinfo_u = 4'd0;
    for (int s = 0; s < 5; s++) begin
      px.bus_data_vld = (s < 4); px.bus_data = hw[s % 4];
      #1;
      n_checks++;
      if (px.pinfo_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_rdy%0d got=%b exp=0", s, px.pinfo_rdy); end
      tick();
      n_checks++;
      if ({px.out_vld, px.out_discard, px.out_data, err_overflow} !== {2'b11, 16'h0000, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold%0d got vld/dis/data/err=%b%b/%h/%b exp=11/0000/0", s,
                 px.out_vld, px.out_discard, px.out_data, err_overflow);
      end
    end
    px.bus_data_vld = 1'b0; px.out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      px.pinfo_u = 4'(k % 2);
      tick();
      n_checks++;
      if ({px.out_vld, px.out_discard, px.out_data} !== {2'b10, exp[k]}) begin
        n_fail++;
        $display("FAIL release_pix%0d got vld/dis/data=%b%b/%h exp=10/%h", k,
                 px.out_vld, px.out_discard, px.out_data, exp[k]);
      end
    end
    px.pinfo_vld = 1'b0;
    tick();
    n_checks++;
    if ({span_idle, err_overflow} !== 2'b10) begin
      n_fail++; $display("FAIL release_end got idle/err=%b%b exp=10", span_idle, err_overflow);
    end
  endtask

  task automatic test_overflow_reset;
    for (int k = 0; k < 5; k++) begin
      px.bus_data_vld = 1'b1; px.bus_data = 16'(16'h1111 * (k + 1));
      tick();
      n_checks++;
      if (err_overflow !== (k == 4)) begin
        n_fail++; $display("FAIL ovf_write%0d got=%b exp=%b", k, err_overflow, (k == 4));
      end
    end
    px.out_rdy = 1'b0;
    px.pinfo_vld = 1'b1; px.pinfo_discard = 1'b0; px.pinfo_u = 4'd1;
    tick();
    n_checks++;
    if ({px.out_vld, px.out_paletted, px.out_data, err_overflow} !== {2'b11, 16'h0011, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_pix got vld/pal/data/err=%b%b/%h/%b exp=11/0011/1",
               px.out_vld, px.out_paletted, px.out_data, err_overflow);
    end
    #2;
    rst_n = 1'b0; px.pinfo_vld = 1'b0; px.bus_data_vld = 1'b0;
    #1;
    n_checks++;
    if ({px.out_vld, px.out_data, px.out_paletted, px.out_discard, err_overflow, span_idle} !== 21'h1) begin
      n_fail++;
      $display("FAIL midreset got=%h exp=000001",
               {px.out_vld, px.out_data, px.out_paletted, px.out_discard, err_overflow, span_idle});
    end
    tick();
    rst_n = 1'b1; px.out_rdy = 1'b1;
    px.bus_data_vld = 1'b1; px.bus_data = 16'hBEEF;
    tick();
    px.bus_data_vld = 1'b0;
    px.pinfo_vld = 1'b1; px.pinfo_u = 4'd3;
    tick();
    n_checks++;
    if ({px.out_vld, px.out_paletted, px.out_data} !== {2'b10, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL post_reset_mode got vld/pal/data=%b%b/%h exp=10/beef",
               px.out_vld, px.out_paletted, px.out_data);
    end
    px.pinfo_vld = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; span_start = 1'b0; span_pixmode = 2'd0;
    px.bus_data_vld = 1'b0; px.bus_data = 16'h0000;
    px.pinfo_u = 4'd0; px.pinfo_discard = 1'b0; px.pinfo_vld = 1'b0;
    px.out_rdy = 1'b1;
    test_reset();
    test_pal4();
    test_argb();
    test_pal1();
    test_discard();
    test_back_to_back();
    test_overflow_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/riscboy_ppu_pixel_unpack.md
Name: riscboy_ppu_pixel_unpack

Overview:
- Data-phase stage directly downstream of the PPU pixel address-generation unit.
- Pairs each returned 16-bit bus halfword with its pixel metadata entry (u low bits, discard flag).
- Extracts one pixel according to the span's pixel mode and presents it to the blender/palette stage on a registered valid/ready stream.
- Discarded pixels (out-of-bounds or transparent tiles) carry no bus data and are emitted immediately, flagged as discard.

Parameters:
- W_DATA, 16, bus data-phase width; always halfword.
- DATA_FIFO_DEPTH, 4, return-data buffer depth. Must be >= the address-stage metadata FIFO depth (4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- span_start  in  1  pulse; latches span_pixmode. Legal only while span_idle=1.
- span_pixmode  in  2  0=ARGB1555, 1=PAL8, 2=PAL4, 3=PAL1
- span_idle  out  1  no metadata pending, data FIFO empty, output register empty
- bus_data_vld  in  1  halfword returned this cycle; no backpressure possible
- bus_data  in  16  returned halfword
- pinfo_u  in  4  low u bits of pixel
- pinfo_discard  in  1  no bus data will arrive for this pixel
- pinfo_vld  in  1  metadata valid
- pinfo_rdy  out  1  metadata pop
- out_vld  out  1  pixel valid
- out_rdy  in  1  downstream accepts
- out_data  out  16  ARGB1555 halfword, or palette index zero-extended
- out_paletted  out  1  out_data is a palette index
- out_discard  out  1  pixel not drawn
- err_overflow  out  1  sticky; bus data arrived with data FIFO full

Behaviour:
- Reset values:
  - out_vld=0, out_data=0, out_paletted=0, out_discard=0, err_overflow=0.
  - Latched pixmode=0; data FIFO empty; span_idle=1.
- Data FIFO:
  - Writes on every bus_data_vld.
  - If full at write: data dropped, err_overflow set until reset. This is unreachable when upstream is compliant.
- Output register load condition: ld = !out_vld || out_rdy.
- Pixel issue:
  - pinfo_rdy = pinfo_vld && ld && (pinfo_discard || !data_fifo_empty).
  - The data FIFO pops on pinfo_rdy && !pinfo_discard.
  - A discard never pops data.
- Registered output on pinfo_rdy:
  - out_vld <= 1.
  - out_discard <= pinfo_discard.
  - out_paletted <= (pixmode != 0).
  - out_data <= extract(head, pixmode, pinfo_u), or 0 when discard.
- Otherwise, if out_rdy: out_vld <= 0.
- Extraction (little-endian within halfword, pixel 0 in LSBs):
  - ARGB1555: full halfword; u ignored.
  - PAL8: byte u[0], zero-extended.
  - PAL4: nibble u[1:0].
  - PAL1: bit u[3:0].
- Latency:
  - Data or discard metadata present in cycle N → out_vld in cycle N+1.
  - Throughput is one pixel/cycle while out_rdy=1.
- Data arriving in the same cycle is not visible until the next cycle (FIFO not bypassed).
- Stall: while out_vld && !out_rdy, all outputs hold stable, pinfo_rdy=0, and bus data continues to queue.
- span_idle = !pinfo_vld && data_fifo_empty && !out_vld.
- span_start is only legal while span_idle=1; asserting it otherwise is a protocol violation (bench asserts).
- Reset mid-span: everything returns to reset values immediately; in-flight data is lost.

Decomposition:
- Shared PPU constants header provides the pixel-mode encodings and the log-pixel-size function. Reuse these; do not redefine.
- Data buffer: instantiate the existing sync_fifo (WIDTH=16, DEPTH=DATA_FIFO_DEPTH).
- Extraction is a combinational function inside this module; no further sub-module.

Test Plan:
- PAL4 span, bus_data=16'hA5C3, four pinfo with u=0..3, out_rdy=1 → out_data 3,C,5,A on consecutive cycles; out_paletted=1; span_idle returns to 1.
- ARGB1555: pinfo u=7, bus_data=16'h8123 → one cycle later out_data=16'h8123, out_paletted=0.
- PAL1: bus_data=16'h8001, pinfo u=0, then a second halfword with same data and u=15 → outputs 1 and 1; same data with u=1 → 0.
- Discard interleave: pinfo {discard}, {u=1}, {discard} with a single PAL8 bus_data=16'h3C7E → out_discard 1,0,1; middle out_data=16'h003C; data FIFO empty at end.
- Backpressure: out_rdy=0 for 5 cycles while 4 halfwords arrive → outputs held stable, no err_overflow; release → 4 pixels in order.
- Overflow and reset: 5 bus_data_vld with no pinfo → err_overflow=1; assert rst_n=0 mid-stream → all outputs 0, span_idle=1.
